// File: rtl/ddr2_v10_1_0002_sequencer_ptr_arb_pkg.sv
// Shared types and constants for the sequencer pointer-manager arbiter.
package ddr2_v10_1_0002_sequencer_ptr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } ptr_arb_state_t;

    typedef logic ptr_arb_mst_t;

    localparam ptr_arb_mst_t M0 = 1'b0;
    localparam ptr_arb_mst_t M1 = 1'b1;

    localparam ptr_arb_mst_t PTR_ARB_LAST_GNT_RST = M1;

endpackage

// File: rtl/ddr2_v10_1_0002_sequencer_ptr_arb_if.sv
// One Avalon-MM port; the arbiter takes two slave views (m0, m1) and one master view (s).
interface ddr2_v10_1_0002_sequencer_ptr_arb_if
    import ddr2_v10_1_0002_sequencer_ptr_arb_pkg::*;
#(
    parameter int AVL_ADDR_WIDTH = 16,
    parameter int AVL_DATA_WIDTH = 32
);
    logic [AVL_ADDR_WIDTH-1:0] address;
    logic                      write;
    logic                      read;
    logic [AVL_DATA_WIDTH-1:0] writedata;
    logic [AVL_DATA_WIDTH-1:0] readdata;
    logic                      waitrequest;

    modport master (output address, write, read, writedata, input readdata, waitrequest);
    modport slave  (input address, write, read, writedata, output readdata, waitrequest);
endinterface

// File: rtl/ddr2_v10_1_0002_sequencer_ptr_arb_pick.sv
// Two-way grant picker. SEQ_PTR_ARB_JTAG_PRIO_EN selects fixed m1 priority instead of round-robin.
module ddr2_v10_1_0002_sequencer_ptr_arb_pick
    import ddr2_v10_1_0002_sequencer_ptr_arb_pkg::*;
(
    input  logic [1:0]   req_i,
    input  ptr_arb_mst_t last_gnt_i,
    output ptr_arb_mst_t winner_o
);

`ifdef SEQ_PTR_ARB_JTAG_PRIO_EN
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt_i;
    assign winner_o        = req_i[1] ? M1 : M0;
`else
    always_comb begin
        winner_o = M0;
        if (req_i == 2'b11) begin
            winner_o = ~last_gnt_i;
        end else if (req_i[1]) begin
            winner_o = M1;
        end
    end
`endif

endmodule

// File: rtl/ddr2_v10_1_0002_sequencer_ptr_arb.sv
// Shares the pointer-manager slave between the NIOS (m0) and JTAG (m1) masters, one transaction at a time.
// Arbitration mode is set by SEQ_PTR_ARB_JTAG_PRIO_EN (see the picker).
module ddr2_v10_1_0002_sequencer_ptr_arb
    import ddr2_v10_1_0002_sequencer_ptr_arb_pkg::*;
#(
    parameter int AVL_DATA_WIDTH = 32,
    parameter int AVL_ADDR_WIDTH = 16
) (
    input  logic                                 avl_clk,
    input  logic                                 avl_reset,
    ddr2_v10_1_0002_sequencer_ptr_arb_if.slave   m0,
    ddr2_v10_1_0002_sequencer_ptr_arb_if.slave   m1,
    ddr2_v10_1_0002_sequencer_ptr_arb_if.master  s
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_ISSUE = 2'(ISSUE);
    localparam logic [1:0] ST_RESP  = 2'(RESP);

    logic [1:0]                state_q, state_d;
    ptr_arb_mst_t              gnt_q, gnt_d;
    ptr_arb_mst_t              last_gnt_q, last_gnt_d;
    ptr_arb_mst_t              winner;
    logic [AVL_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AVL_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [AVL_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      s_rd_q, s_rd_d;
    logic                      s_wr_q, s_wr_d;
    logic [1:0]                wait_q, wait_d;
    logic [1:0]                req;

    assign req = {m1.read | m1.write, m0.read | m0.write};

    ddr2_v10_1_0002_sequencer_ptr_arb_pick u_pick (
        .req_i      (req),
        .last_gnt_i (last_gnt_q),
        .winner_o   (winner)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        s_rd_d     = s_rd_q;
        s_wr_d     = s_wr_q;
        wait_d     = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = winner;
                    addr_d  = (winner == M1) ? m1.address   : m0.address;
                    wdata_d = (winner == M1) ? m1.writedata : m0.writedata;
                    // A master raising read and write together is treated as a write.
                    s_wr_d  = (winner == M1) ? m1.write : m0.write;
                    s_rd_d  = (winner == M1) ? (m1.read & ~m1.write) : (m0.read & ~m0.write);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!s.waitrequest) begin
                    if (s_rd_q) begin
                        rdata_d = s.readdata;
                    end
                    last_gnt_d     = gnt_q;
                    s_rd_d         = 1'b0;
                    s_wr_d         = 1'b0;
                    wait_d[gnt_q]  = 1'b0;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                wait_d  = 2'b11;
                state_d = ST_IDLE;
            end
            default: begin
                s_rd_d  = 1'b0;
                s_wr_d  = 1'b0;
                wait_d  = 2'b11;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge avl_clk) begin
        if (avl_reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= M0;
            last_gnt_q <= PTR_ARB_LAST_GNT_RST;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            s_rd_q     <= 1'b0;
            s_wr_q     <= 1'b0;
            wait_q     <= 2'b11;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            s_rd_q     <= s_rd_d;
            s_wr_q     <= s_wr_d;
            wait_q     <= wait_d;
        end
    end

    assign s.address      = addr_q;
    assign s.writedata    = wdata_q;
    assign s.read         = s_rd_q;
    assign s.write        = s_wr_q;

    assign m0.waitrequest = wait_q[0];
    assign m1.waitrequest = wait_q[1];
    assign m0.readdata    = (gnt_q == M0) ? rdata_q : '0;
    assign m1.readdata    = (gnt_q == M1) ? rdata_q : '0;

endmodule
